// File: rtl/q_add8_pack.sv
// Output stage of the quantized 8-bit adder pipeline. Packs the adder's byte
// stream into 32-bit words, buffers them, and writes them out over REQ/ACK.
module q_add8_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET_X,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              IN_EN,
  input  logic [7:0]        IN_DATA,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  output logic [3:0]        WR_BE,
  input  logic              WR_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW,
  output logic [LEN_W-1:0]  BYTE_CNT,
  output logic [7:0]        MIN_OUT,
  output logic [7:0]        MAX_OUT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  byte_cnt_reg;
  logic [7:0]        min_reg, max_reg;
  logic              overflow_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic [31:0]       acc_data_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              wr_req_reg;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [3:0]        fifo_be   [FIFO_DEPTH];

  logic [1:0]  lane;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic        accept, last_byte, push, pop, full, push_ok, drop;

  assign lane      = byte_cnt_reg[1:0];
  assign accept    = (state_reg == ST_RUN) && IN_EN;
  assign last_byte = (byte_cnt_reg == len_reg - LEN_W'(1));
  assign push      = accept && ((lane == 2'd3) || last_byte);
  assign pop       = wr_req_reg && WR_ACK;
  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Lanes below the current one keep accumulated bytes, lanes above stay empty.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_data[8*gi +: 8] = (lane == 2'(gi)) ? IN_DATA :
                                    ((lane > 2'(gi)) ? acc_data_reg[8*gi +: 8] : 8'h00);
      assign word_be[gi]          = (lane >= 2'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (START) state_next = (LEN == '0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (accept && last_byte) state_next = ST_DRAIN;
      ST_DRAIN: if (count_reg == '0) state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      state_reg    <= ST_IDLE;
      base_reg     <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      min_reg      <= 8'hFF;
      max_reg      <= 8'h00;
      overflow_reg <= 1'b0;
      word_idx_reg <= '0;
      acc_data_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && START) begin
        base_reg     <= BASE_ADDR;
        len_reg      <= LEN;
        byte_cnt_reg <= '0;
        min_reg      <= 8'hFF;
        max_reg      <= 8'h00;
        overflow_reg <= 1'b0;
        word_idx_reg <= '0;
      end
      if (accept) begin
        byte_cnt_reg <= byte_cnt_reg + LEN_W'(1);
        acc_data_reg <= word_data;
        if (IN_DATA < min_reg) min_reg <= IN_DATA;
        if (IN_DATA > max_reg) max_reg <= IN_DATA;
      end
      // Address advances even for dropped words, leaving a visible hole.
      if (push) word_idx_reg <= word_idx_reg + ADDR_W'(1);
      if (drop) overflow_reg <= 1'b1;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg  <= count_next;
      wr_req_reg <= (count_next != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_addr[wr_ptr_reg] <= base_reg + word_idx_reg;
      fifo_data[wr_ptr_reg] <= word_data;
      fifo_be[wr_ptr_reg]   <= word_be;
    end
  end

  assign WR_REQ   = wr_req_reg;
  assign WR_ADDR  = fifo_addr[rd_ptr_reg];
  assign WR_DATA  = fifo_data[rd_ptr_reg];
  assign WR_BE    = fifo_be[rd_ptr_reg];
  assign BUSY     = (state_reg != ST_IDLE);
  assign DONE     = (state_reg == ST_FIN);
  assign OVERFLOW = overflow_reg;
  assign BYTE_CNT = byte_cnt_reg;
  assign MIN_OUT  = min_reg;
  assign MAX_OUT  = max_reg;

endmodule

// File: tb/tb_q_add8_pack.sv
// Directed bench for q_add8_pack: table of whole jobs with immediate ACK, plus
// hand sequences for overflow, zero length, gapped input with stalls, and reset.
module tb_q_add8_pack;

  logic        CLK = 1'b0;
  logic        RESET_X = 1'b1;
  logic        START = 1'b0;
  logic [15:0] BASE_ADDR = '0;
  logic [15:0] LEN = '0;
  logic        IN_EN = 1'b0;
  logic [7:0]  IN_DATA = '0;
  logic        WR_REQ;
  logic [15:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [3:0]  WR_BE;
  logic        WR_ACK = 1'b1;
  logic        BUSY, DONE, OVERFLOW;
  logic [15:0] BYTE_CNT;
  logic [7:0]  MIN_OUT, MAX_OUT;

  q_add8_pack #(.FIFO_DEPTH(4), .ADDR_W(16), .LEN_W(16)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .IN_EN(IN_EN), .IN_DATA(IN_DATA), .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .WR_BE(WR_BE), .WR_ACK(WR_ACK), .BUSY(BUSY), .DONE(DONE),
    .OVERFLOW(OVERFLOW), .BYTE_CNT(BYTE_CNT), .MIN_OUT(MIN_OUT), .MAX_OUT(MAX_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  first;
    int          n_wr;
    logic [31:0] first_data;
    logic [15:0] last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_be;
    logic [7:0]  mn;
    logic [7:0]  mx;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int req_cycles = 0;
  bit rand_ack = 0;
  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_be[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Records accepted writes, DONE cycles, and write-port stability under stall.
  initial begin
    bit          stall_prev = 0;
    logic [15:0] pa;
    logic [31:0] pd;
    logic [3:0]  pb;
    forever begin
      @(negedge CLK);
      if (RESET_X) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("stall_req_held", 32'(WR_REQ), 32'd1);
          check("stall_addr", 32'(WR_ADDR), 32'(pa));
          check("stall_data", WR_DATA, pd);
          check("stall_be", 32'(WR_BE), 32'(pb));
        end
        if (DONE) done_cnt++;
        if (WR_REQ) req_cycles++;
        if (WR_REQ && WR_ACK) begin
          q_addr.push_back(WR_ADDR);
          q_data.push_back(WR_DATA);
          q_be.push_back(WR_BE);
          $display("write addr=%h data=%h be=%b", WR_ADDR, WR_DATA, WR_BE);
        end
        stall_prev = WR_REQ && !WR_ACK;
        pa = WR_ADDR; pd = WR_DATA; pb = WR_BE;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ack) WR_ACK = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_log();
    q_addr.delete(); q_data.delete(); q_be.delete();
    done_cnt = 0;
    req_cycles = 0;
  endtask

  task automatic start_job(input logic [15:0] b, input logic [15:0] l);
    BASE_ADDR = b; LEN = l; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic feed(input logic [7:0] first, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      IN_EN = 1'b1;
      IN_DATA = first + 8'(i);
      tick();
      if (gapped) begin
        IN_EN = 1'b0;
        tick();
      end
    end
    IN_EN = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int c = 0; c < bound && done_cnt < 1; c++) tick();
    tick(); tick();
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic run_vec(input int v);
    clear_log();
    start_job(vecs[v].base, vecs[v].len);
    feed(vecs[v].first, int'(vecs[v].len), 0);
    wait_done(200);
    check("n_writes", 32'(q_addr.size()), 32'(vecs[v].n_wr));
    check("first_addr", 32'(q_addr[0]), 32'(vecs[v].base));
    check("first_data", q_data[0], vecs[v].first_data);
    check("last_addr", 32'(q_addr[$]), 32'(vecs[v].last_addr));
    check("last_data", q_data[$], vecs[v].last_data);
    check("last_be", 32'(q_be[$]), 32'(vecs[v].last_be));
    check("min", 32'(MIN_OUT), 32'(vecs[v].mn));
    check("max", 32'(MAX_OUT), 32'(vecs[v].mx));
    check("byte_cnt", 32'(BYTE_CNT), 32'(vecs[v].len));
    check("overflow_clr", 32'(OVERFLOW), 32'd0);
    check("busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //          base     len    first  n  first_data     last_addr last_data     be      min    max
    vecs[0] = '{16'h0100, 16'd8, 8'h01, 2, 32'h04030201, 16'h0101, 32'h08070605, 4'hF,   8'h01, 8'h08};
    vecs[1] = '{16'h0200, 16'd6, 8'h10, 2, 32'h13121110, 16'h0201, 32'h00001514, 4'b0011, 8'h10, 8'h15};
    vecs[2] = '{16'hFFFF, 16'd5, 8'hF0, 2, 32'hF3F2F1F0, 16'h0000, 32'h000000F4, 4'b0001, 8'hF0, 8'hF4};
    vecs[3] = '{16'h0010, 16'd1, 8'h80, 1, 32'h00000080, 16'h0010, 32'h00000080, 4'b0001, 8'h80, 8'h80};
    vecs[4] = '{16'h0020, 16'd4, 8'hFC, 1, 32'hFFFEFDFC, 16'h0020, 32'hFFFEFDFC, 4'hF,   8'hFC, 8'hFF};
    vecs[5] = '{16'h0030, 16'd3, 8'hFF, 1, 32'h000100FF, 16'h0030, 32'h000100FF, 4'b0111, 8'h00, 8'hFF};

    repeat (3) @(posedge CLK);
    #1 RESET_X = 1'b0;
    @(negedge CLK);
    check("rst_wr_req", 32'(WR_REQ), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    check("rst_byte_cnt", 32'(BYTE_CNT), 32'd0);
    check("rst_min", 32'(MIN_OUT), 32'hFF);
    check("rst_max", 32'(MAX_OUT), 32'h00);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Overflow: ACK withheld while 32 bytes arrive; only the first 4 words survive.
    clear_log();
    WR_ACK = 1'b0;
    start_job(16'h0400, 16'd32);
    feed(8'h00, 32, 0);
    repeat (8) tick();
    check("ovf_flag", 32'(OVERFLOW), 32'd1);
    check("ovf_no_done_yet", 32'(done_cnt), 32'd0);
    WR_ACK = 1'b1;
    wait_done(50);
    check("ovf_n_writes", 32'(q_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      check("ovf_addr", 32'(q_addr[i]), 32'h0400 + 32'(i));
      check("ovf_data", q_data[i], {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    end
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Zero-length job: one BUSY/DONE cycle and no write requests.
    clear_log();
    BASE_ADDR = 16'h0900; LEN = 16'd0; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK);
    check("len0_busy", 32'(BUSY), 32'd1);
    check("len0_done", 32'(DONE), 32'd1);
    check("len0_ovf_cleared", 32'(OVERFLOW), 32'd0);
    tick();
    @(negedge CLK);
    check("len0_busy_after", 32'(BUSY), 32'd0);
    check("len0_done_after", 32'(DONE), 32'd0);
    repeat (3) tick();
    check("len0_no_req", 32'(req_cycles), 32'd0);
    check("len0_done_cnt", 32'(done_cnt), 32'd1);

    // START while running must not relatch base/length.
    clear_log();
    start_job(16'h0500, 16'd4);
    feed(8'h40, 2, 0);
    BASE_ADDR = 16'h0600; LEN = 16'd8; START = 1'b1;
    IN_EN = 1'b1; IN_DATA = 8'h42;
    tick();
    START = 1'b0; IN_DATA = 8'h43;
    tick();
    IN_EN = 1'b0;
    wait_done(50);
    check("rs_n_writes", 32'(q_addr.size()), 32'd1);
    check("rs_addr", 32'(q_addr[0]), 32'h0500);
    check("rs_data", q_data[0], 32'h43424140);
    check("rs_byte_cnt", 32'(BYTE_CNT), 32'd4);

    // Gapped input, two surplus bytes, random ACK stalls.
    clear_log();
    rand_ack = 1;
    start_job(16'h0700, 16'd8);
    feed(8'h21, 10, 1);
    wait_done(200);
    rand_ack = 0;
    WR_ACK = 1'b1;
    check("gap_n_writes", 32'(q_addr.size()), 32'd2);
    check("gap_addr0", 32'(q_addr[0]), 32'h0700);
    check("gap_data0", q_data[0], 32'h24232221);
    check("gap_addr1", 32'(q_addr[$]), 32'h0701);
    check("gap_data1", q_data[$], 32'h28272625);
    check("gap_byte_cnt", 32'(BYTE_CNT), 32'd8);
    check("gap_max", 32'(MAX_OUT), 32'h28);

    // Reset mid-job: everything returns to reset values, no DONE follows.
    clear_log();
    start_job(16'h0800, 16'd16);
    feed(8'h50, 5, 0);
    RESET_X = 1'b1;
    #2;
    check("mrst_wr_req", 32'(WR_REQ), 32'd0);
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_byte_cnt", 32'(BYTE_CNT), 32'd0);
    check("mrst_min", 32'(MIN_OUT), 32'hFF);
    check("mrst_max", 32'(MAX_OUT), 32'h00);
    tick();
    RESET_X = 1'b0;
    done_cnt = 0;
    repeat (20) tick();
    check("mrst_no_done", 32'(done_cnt), 32'd0);
    check("mrst_idle", 32'(BUSY), 32'd0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
